// File: rtl/rom_dds_scheduler.sv
// Time-multiplexes one registered waveform ROM across NCH DDS phase accumulators.
// Define BIPOLAR_OUT_EN to emit two's-complement samples (MSB of ROM data inverted).
module rom_dds_scheduler #(
    parameter int unsigned NCH     = 4,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ACC_W   = 32,
    parameter int unsigned ROM_LAT = 1,
    localparam int unsigned CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              freq_wr,
    input  logic [CH_W-1:0]   freq_ch,
    input  logic [ACC_W-1:0]  freq_word,
    input  logic [NCH-1:0]    ch_enable,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] sample_out,
    output logic [CH_W-1:0]   sample_ch,
    output logic              sample_valid,
    output logic              busy,
    output logic              overrun,
    input  logic              overrun_clr
);

    localparam int unsigned DRAIN_W = $clog2(ROM_LAT + 2);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    state_e              r_state, w_state_nxt;
    logic [CH_W-1:0]     r_slot, w_slot_nxt;
    logic [DRAIN_W-1:0]  r_drain, w_drain_nxt;

    logic [ACC_W-1:0]    r_acc  [NCH];
    logic [ACC_W-1:0]    r_freq [NCH];
    logic [ADDR_W-1:0]   r_rom_addr;
    logic                r_overrun;

    // Tag stage i lines up with the ROM access i cycles after the address register.
    logic [CH_W-1:0]     r_tag_ch  [ROM_LAT+1];
    logic                r_tag_vld [ROM_LAT+1];

    logic [DATA_W-1:0]   r_sample;
    logic [CH_W-1:0]     r_sample_ch;
    logic                r_sample_vld;

    logic                w_busy;
    logic                w_issue;
    logic                w_slot_en;
    logic [DATA_W-1:0]   w_sample;

    assign w_busy    = (r_state != StIdle);
    assign w_issue   = (r_state == StIssue);
    assign w_slot_en = ch_enable[r_slot];

`ifdef BIPOLAR_OUT_EN
    assign w_sample = rom_data ^ {1'b1, {(DATA_W-1){1'b0}}};
`else
    assign w_sample = rom_data;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot;
        w_drain_nxt = r_drain;
        unique case (r_state)
            StIdle: begin
                if (tick) begin
                    w_state_nxt = StIssue;
                    w_slot_nxt  = '0;
                end
            end
            StIssue: begin
                if (r_slot == CH_W'(NCH - 1)) begin
                    w_state_nxt = StDrain;
                    w_drain_nxt = '0;
                end else begin
                    w_slot_nxt = r_slot + 1'b1;
                end
            end
            StDrain: begin
                if (r_drain == DRAIN_W'(ROM_LAT)) begin
                    w_state_nxt = StIdle;
                end else begin
                    w_drain_nxt = r_drain + 1'b1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_slot    <= '0;
            r_drain   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_slot  <= w_slot_nxt;
            r_drain <= w_drain_nxt;
            // A dropped tick outranks a simultaneous clear.
            if (tick && w_busy) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NCH); i++) begin
                r_freq[i] <= '0;
            end
        end else if (freq_wr && (int'(freq_ch) < int'(NCH))) begin
            r_freq[freq_ch] <= freq_word;
        end
    end

    // Disabled slots park their accumulator at zero so re-enable restarts at phase 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NCH); i++) begin
                r_acc[i] <= '0;
            end
            r_rom_addr <= '0;
        end else if (w_issue) begin
            if (w_slot_en) begin
                r_rom_addr     <= r_acc[r_slot][ACC_W-1 -: ADDR_W];
                r_acc[r_slot] <= r_acc[r_slot] + r_freq[r_slot];
            end else begin
                r_rom_addr     <= '0;
                r_acc[r_slot] <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= int'(ROM_LAT); i++) begin
                r_tag_ch[i]  <= '0;
                r_tag_vld[i] <= 1'b0;
            end
            r_sample     <= '0;
            r_sample_ch  <= '0;
            r_sample_vld <= 1'b0;
        end else begin
            r_tag_ch[0]  <= r_slot;
            r_tag_vld[0] <= w_issue && w_slot_en;
            for (int i = 1; i <= int'(ROM_LAT); i++) begin
                r_tag_ch[i]  <= r_tag_ch[i-1];
                r_tag_vld[i] <= r_tag_vld[i-1];
            end
            r_sample_vld <= r_tag_vld[ROM_LAT];
            if (r_tag_vld[ROM_LAT]) begin
                r_sample    <= w_sample;
                r_sample_ch <= r_tag_ch[ROM_LAT];
            end
        end
    end

    assign rom_addr     = r_rom_addr;
    assign sample_out   = r_sample;
    assign sample_ch    = r_sample_ch;
    assign sample_valid = r_sample_vld;
    assign busy         = w_busy;
    assign overrun      = r_overrun;

endmodule
